// File: rtl/lfsr_run_ctrl_pkg.sv
// Shared constants and state encoding for the LFSR run sequencer.
// State values are fixed so that debug probes can decode the 3-bit state directly.
package lfsr_ctrl_pkg;

    localparam int              LFSR_W      = 17;
    localparam logic [LFSR_W-1:0] DEF_SEED  = 17'h00001;
    localparam int              DEF_RUN_LEN = (1 << LFSR_W) - 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_SHOW    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        LOAD    = ST_LOAD,
        RUN     = ST_RUN,
        CAPTURE = ST_CAPTURE,
        SHOW    = ST_SHOW
    } state_t;

endpackage

// File: rtl/lfsr_run_ctrl_if.sv
// Control/status bundle between the run sequencer and the LFSR/counter/display datapath.
// Optional seed_in wire exists only when LFSR_RUN_CTRL_SEED_IN_EN is defined.
interface lfsr_run_ctrl_if #(
    parameter int WIDTH = 17
);
    logic             start;
    logic             abort;
    logic             step_tick;
    logic             lfsr_max_tick;
    logic [WIDTH-1:0] msb_count;
`ifdef LFSR_RUN_CTRL_SEED_IN_EN
    logic [WIDTH-1:0] seed_in;
`endif
    logic             lfsr_load;
    logic [WIDTH-1:0] lfsr_seed;
    logic             sh_en;
    logic             cnt_clr;
    logic [WIDTH-1:0] disp_value;
    logic             disp_valid;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
`ifdef LFSR_RUN_CTRL_SEED_IN_EN
        output seed_in,
`endif
        output start, abort, step_tick, lfsr_max_tick, msb_count,
        input  lfsr_load, lfsr_seed, sh_en, cnt_clr,
        input  disp_value, disp_valid, busy, done, err
    );

    modport slave (
`ifdef LFSR_RUN_CTRL_SEED_IN_EN
        input  seed_in,
`endif
        input  start, abort, step_tick, lfsr_max_tick, msb_count,
        output lfsr_load, lfsr_seed, sh_en, cnt_clr,
        output disp_value, disp_valid, busy, done, err
    );

endinterface

// File: rtl/lfsr_run_ctrl_rise_detect.sv
// Registered rising-edge detector: rise pulses for one cycle, one clock after level goes high.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_reg;
    logic rise_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            level_reg <= level;
            rise_reg  <= level & ~level_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/lfsr_run_ctrl.sv
// Run sequencer: seeds the LFSR, gates stepping for one period, captures the MSB count.
// Define LFSR_RUN_CTRL_SEED_IN_EN to take the seed from seed_in instead of the SEED constant.
module lfsr_run_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int               WIDTH   = LFSR_W,
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(DEF_SEED),
    parameter int               RUN_LEN = DEF_RUN_LEN
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_run_ctrl_if.slave bus
);

    localparam int             CNT_W = $clog2(RUN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_LEN - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   step_cnt_reg;
    logic               mismatch_reg;
    logic               err_reg;
    logic               disp_valid_reg;
    logic [WIDTH-1:0]   disp_value_reg;
    logic               start_rise;
    logic               tick_last;
    logic               exit_run;
    logic               mismatch_now;
    logic               capture_ok;
    logic               entering_load;

    rise_detect u_start_rise (
        .clk   (clk),
        .reset (reset),
        .level (bus.start),
        .rise  (start_rise)
    );

    // The step counter holds the number of ticks already taken, so the final tick sees LAST.
    assign tick_last     = bus.step_tick && (step_cnt_reg == LAST);
    assign exit_run      = tick_last || bus.lfsr_max_tick;
    assign mismatch_now  = (bus.lfsr_max_tick && (step_cnt_reg != LAST)) ||
                           (tick_last && !bus.lfsr_max_tick);
    assign capture_ok    = (state_reg == CAPTURE) && !bus.abort;
    assign entering_load = (state_next == LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_rise) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (exit_run) state_next = CAPTURE;
            CAPTURE: state_next = SHOW;
            SHOW:    if (start_rise) state_next = LOAD;
            default: state_next = IDLE;
        endcase
        if (bus.abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt_reg <= '0;
        end else if (state_reg == LOAD) begin
            step_cnt_reg <= '0;
        end else if ((state_reg == RUN) && bus.step_tick && (step_cnt_reg != LAST)) begin
            step_cnt_reg <= step_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch_reg <= 1'b0;
        end else if (state_reg == LOAD) begin
            mismatch_reg <= 1'b0;
        end else if ((state_reg == RUN) && exit_run) begin
            mismatch_reg <= mismatch_now;
        end
    end

    // err and disp_valid drop on the edge into LOAD so they already read 0 during LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg        <= 1'b0;
            disp_valid_reg <= 1'b0;
            disp_value_reg <= '0;
        end else begin
            if (entering_load) begin
                err_reg        <= 1'b0;
                disp_valid_reg <= 1'b0;
            end else if (capture_ok) begin
                err_reg        <= err_reg | mismatch_reg;
                disp_valid_reg <= 1'b1;
            end
            if (capture_ok) begin
                disp_value_reg <= bus.msb_count;
            end
        end
    end

`ifdef LFSR_RUN_CTRL_SEED_IN_EN
    logic [WIDTH-1:0] seed_reg;

    // An all-zero seed would lock the LFSR, so it falls back to SEED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_reg <= SEED;
        end else if (entering_load) begin
            seed_reg <= (bus.seed_in == '0) ? SEED : bus.seed_in;
        end
    end

    assign bus.lfsr_seed = seed_reg;
`else
    assign bus.lfsr_seed = SEED;
`endif

    assign bus.lfsr_load  = (state_reg == LOAD);
    assign bus.cnt_clr    = (state_reg == LOAD);
    assign bus.sh_en      = (state_reg == RUN) && bus.step_tick && !bus.abort;
    assign bus.busy       = (state_reg == LOAD) || (state_reg == RUN) || (state_reg == CAPTURE);
    assign bus.done       = capture_ok;
    assign bus.err        = err_reg;
    assign bus.disp_valid = disp_valid_reg;
    assign bus.disp_value = disp_value_reg;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Randomised scoreboard bench for lfsr_run_ctrl at WIDTH=3, RUN_LEN=7.
// Build with LFSR_RUN_CTRL_SEED_IN_EN defined to exercise the seed_in path as well.
module tb_lfsr_run_ctrl;

    localparam int             W      = 3;
    localparam int             RL     = 7;
    localparam logic [W-1:0]   SEED_V = 3'b001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_run_ctrl_if #(.WIDTH(W)) bus ();

    lfsr_run_ctrl #(
        .WIDTH   (W),
        .SEED    (SEED_V),
        .RUN_LEN (RL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] value;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           run_id   = 0;
    logic [W-1:0] seed_drive;
    logic [W-1:0] last_msb;

`ifdef LFSR_RUN_CTRL_SEED_IN_EN
    assign bus.seed_in = seed_drive;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_seed();
`ifdef LFSR_RUN_CTRL_SEED_IN_EN
        return (seed_drive == '0) ? SEED_V : seed_drive;
`else
        return SEED_V;
`endif
    endfunction

    // Raise start on a negedge and wait (bounded) for the LOAD cycle.
    task automatic do_start(output bit ok);
        int lat;
        lat = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k <= 4 && lat == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.lfsr_load === 1'b1) lat = k;
        end
        check("load_latency", 32'(lat), 32'd2);
        ok = (lat != 0);
        if (ok) begin
            check("cnt_clr_at_load", 32'(bus.cnt_clr), 32'd1);
            check("busy_at_load", 32'(bus.busy), 32'd1);
            check("err_cleared_at_load", 32'(bus.err), 32'd0);
            check("disp_valid_cleared_at_load", 32'(bus.disp_valid), 32'd0);
            check("seed_at_load", 32'(bus.lfsr_seed), 32'(exp_seed()));
        end
    endtask

    // Called in the LOAD cycle; issues n step ticks with random gaps, max_tick on tick max_pos.
    task automatic run_ticks(input int n, input int max_pos);
        @(negedge clk);
        for (int t = 1; t <= n; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.step_tick     = 1'b1;
            bus.lfsr_max_tick = (t == max_pos);
            #1;
            check("sh_en_in_run", 32'(bus.sh_en), 32'd1);
            @(negedge clk);
            bus.step_tick     = 1'b0;
            bus.lfsr_max_tick = 1'b0;
        end
    endtask

    task automatic run_once(input int max_pos, input logic [W-1:0] msb, input bit hold);
        bit ok;
        int exit_t;
        exp_t e;
        // A run ends at whichever comes first; it is clean only if the period is exactly RL.
        exit_t  = (max_pos < RL) ? max_pos : RL;
        e.value = msb;
        e.err   = (max_pos != RL);
        sb.push_back(e);
        bus.msb_count = msb;
        last_msb      = msb;
        run_id++;
        $display("run %0d: max_tick_at=%0d ticks=%0d msb=%0d seed=%0d exp_err=%0d",
                 run_id, max_pos, exit_t, msb, exp_seed(), e.err);
        do_start(ok);
        if (!ok) return;
        if (!hold) bus.start = 1'b0;
        run_ticks(exit_t, max_pos);
        @(negedge clk);
        check("busy_in_show", 32'(bus.busy), 32'd0);
        check("disp_valid_in_show", 32'(bus.disp_valid), 32'd1);
        bus.step_tick = 1'b1;
        #1;
        check("sh_en_gated_in_show", 32'(bus.sh_en), 32'd0);
        @(negedge clk);
        bus.step_tick = 1'b0;
    endtask

    // Scoreboard monitor: each done pulse consumes one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                check("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    @(negedge clk);
                    check("disp_value", 32'(bus.disp_value), 32'(e.value));
                    check("err", 32'(bus.err), 32'(e.err));
                    check("disp_valid_after_done", 32'(bus.disp_valid), 32'd1);
                    check("done_one_cycle", 32'(bus.done), 32'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit saw_busy;
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.step_tick     = 1'b0;
        bus.lfsr_max_tick = 1'b0;
        bus.msb_count     = '0;
        seed_drive        = '0;
        last_msb          = '0;

        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_lfsr_load", 32'(bus.lfsr_load), 32'd0);
        check("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
        check("rst_disp_value", 32'(bus.disp_value), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_seed", 32'(bus.lfsr_seed), 32'(SEED_V));
        reset = 1'b0;

        saw_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy === 1'b1) saw_busy = 1'b1;
        end
        check("idle_stays_idle", 32'(saw_busy), 32'd0);

        // Clean full-period run, then a short-period mismatch, then a clean run clearing err.
        seed_drive = 3'd5;
        run_once(7, 3'd4, 1'b0);
        seed_drive = 3'd0;
        run_once(5, 3'd3, 1'b0);
        seed_drive = 3'd6;
        run_once(9, 3'd5, 1'b0);
        run_once(7, 3'd7, 1'b0);

        // Abort in SHOW keeps the captured result.
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_show_busy", 32'(bus.busy), 32'd0);
        check("abort_show_disp_valid", 32'(bus.disp_valid), 32'd1);
        check("abort_show_disp_value", 32'(bus.disp_value), 32'(last_msb));

        // Abort in RUN after three ticks.
        $display("abort run: 3 ticks then abort");
        do_start(ok);
        bus.start = 1'b0;
        if (ok) begin
            run_ticks(3, 99);
            bus.step_tick = 1'b1;
            bus.abort     = 1'b1;
            #1;
            check("abort_sh_en_gate", 32'(bus.sh_en), 32'd0);
            @(negedge clk);
            bus.step_tick = 1'b0;
            bus.abort     = 1'b0;
            check("abort_run_idle", 32'(bus.busy), 32'd0);
            check("abort_run_disp_valid", 32'(bus.disp_valid), 32'd0);
            repeat (3) @(negedge clk);
            check("abort_run_stays_idle", 32'(bus.busy), 32'd0);
        end

        // start held high across the whole run and SHOW: exactly one run.
        run_once(7, 3'd6, 1'b1);
        saw_busy = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.busy === 1'b1) saw_busy = 1'b1;
        end
        check("held_start_no_retrigger", 32'(saw_busy), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        run_once(7, 3'd2, 1'b0);

        repeat (12) begin
            seed_drive = W'($urandom_range(0, 7));
            run_once(int'($urandom_range(1, 9)), W'($urandom_range(0, 7)), 1'b0);
        end

        // Asynchronous reset in the middle of a run.
        $display("reset mid-run: 2 ticks then reset");
        seed_drive = 3'd3;
        do_start(ok);
        bus.start = 1'b0;
        if (ok) begin
            run_ticks(2, 99);
            #2;
            reset = 1'b1;
            #1;
            check("midrst_busy", 32'(bus.busy), 32'd0);
            check("midrst_lfsr_load", 32'(bus.lfsr_load), 32'd0);
            check("midrst_cnt_clr", 32'(bus.cnt_clr), 32'd0);
            check("midrst_disp_valid", 32'(bus.disp_valid), 32'd0);
            check("midrst_disp_value", 32'(bus.disp_value), 32'd0);
            check("midrst_err", 32'(bus.err), 32'd0);
            check("midrst_seed", 32'(bus.lfsr_seed), 32'(SEED_V));
            @(negedge clk);
            reset = 1'b0;
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_run_ctrl.md
Name: lfsr_run_ctrl

Overview:
- Sequencer for the 17-bit LFSR / MSB-counter / seven-segment datapath.
- On a start request it seeds the LFSR and clears the MSB counter.
- It then gates LFSR shifting with the scaled-clock step tick for one full sequence period.
- At the end it latches the MSB-count result for the display and flags completion, or flags an error if the LFSR period does not match.

Parameters:
- WIDTH, 17, LFSR and counter width in bits.
- SEED, 17'h00001, default non-zero LFSR seed loaded at the start of each run.
- RUN_LEN, 131071, steps per run; equals 2^WIDTH-1 for a maximal-length LFSR.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  run request, level; an internal rising-edge detect makes the request.
- abort  input  1  level; returns the block to IDLE from any state.
- step_tick  input  1  one-cycle enable from the clock scaler; one LFSR step per tick.
- lfsr_max_tick  input  1  LFSR period-complete pulse.
- msb_count  input  WIDTH  current MSB-ones count from the counter.
- lfsr_load  output  1  one-cycle pulse; LFSR loads lfsr_seed.
- lfsr_seed  output  WIDTH  seed value presented during lfsr_load.
- sh_en  output  1  LFSR shift enable; equals step_tick in RUN, otherwise 0.
- cnt_clr  output  1  one-cycle MSB-counter clear; coincides with lfsr_load.
- disp_value  output  WIDTH  latched result for the display.
- disp_valid  output  1  high while disp_value holds a completed run's result.
- busy  output  1  high in LOAD, RUN and CAPTURE.
- done  output  1  one-cycle pulse when a result is captured.
- err  output  1  sticky period-mismatch flag; cleared in LOAD.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; step counter and start-edge register clear.
  - All outputs go to 0, except lfsr_seed, which is SEED.
- States:
  - IDLE: on a start rising edge, go to LOAD.
  - LOAD: one cycle. lfsr_load=1, cnt_clr=1, step counter cleared to 0, err cleared, disp_valid cleared. Always goes to RUN.
  - RUN: sh_en=step_tick. Each step_tick increments the step counter. Leave RUN on a step_tick when the counter equals RUN_LEN-1, or when lfsr_max_tick=1, whichever comes first; go to CAPTURE.
  - CAPTURE: one cycle. disp_value<=msb_count; done=1. Go to SHOW.
  - SHOW: disp_valid=1, holds indefinitely. A start rising edge goes to LOAD.
- Latency: the start edge is registered. lfsr_load asserts 2 cycles after start rises (edge-detect cycle plus IDLE transition). done asserts exactly 1 cycle after RUN exits.
- err:
  - Set in CAPTURE if lfsr_max_tick ended the run while the step counter ≠ RUN_LEN-1.
  - Also set if the counter reached RUN_LEN-1 without lfsr_max_tick on that same tick.
  - Holds until the next LOAD.
- Step counter: width ceil(log2(RUN_LEN+1)). It never wraps; it saturates at RUN_LEN-1.
- Simultaneous events:
  - abort beats every other condition. abort in any state goes to IDLE next cycle, with sh_en=0 immediately (combinational gate).
  - disp_value and disp_valid are preserved on abort, except when abort occurs in LOAD/RUN, where disp_valid has already been cleared.
  - A start edge while busy is ignored and is not queued.
  - start held high across SHOW does not retrigger; a new rising edge is required.
- Reset mid-run: immediate return to IDLE; LFSR/counter contents are don't-care until the next LOAD.

Optional Feature:
- Macro LFSR_RUN_CTRL_SEED_IN_EN.
- Defined:
  - Adds input port seed_in (WIDTH), sampled in the IDLE→LOAD transition cycle and driven on lfsr_seed during LOAD.
  - A seed_in of 0 is replaced by SEED, since an all-zero LFSR state locks up.
- Undefined: no seed_in port; lfsr_seed is the constant SEED.

Decomposition:
- Package lfsr_ctrl_pkg holds:
  - state encoding constants ST_IDLE=0, ST_LOAD=1, ST_RUN=2, ST_CAPTURE=3, ST_SHOW=4 (3-bit);
  - LFSR_W=17;
  - DEF_SEED;
  - DEF_RUN_LEN.
- One natural sub-module: rise_detect (registered edge detector, async active-high reset), used for start.

Test Plan:
- Reset then idle: assert reset mid-cycle -> all outputs 0 asynchronously, lfsr_seed=SEED; with start held low for 20 cycles, busy stays 0.
- Full run (WIDTH=3, RUN_LEN=7):
  - start rises -> lfsr_load and cnt_clr pulse 2 cycles later;
  - 7 step_ticks with lfsr_max_tick on the 7th -> CAPTURE;
  - msb_count=4 -> disp_value=4, one-cycle done, disp_valid=1, err=0.
- Period mismatch: lfsr_max_tick on the 5th tick with RUN_LEN=7 -> exit to CAPTURE, err=1; a new start clears err at LOAD.
- Abort in RUN after 3 ticks -> sh_en=0 the same cycle, IDLE next cycle, done never pulses, disp_valid=0.
- start held high through a whole run -> exactly one run; a second rising edge in SHOW -> new LOAD and disp_valid drops.
- With LFSR_RUN_CTRL_SEED_IN_EN: seed_in=5 -> lfsr_seed=5 during LOAD; seed_in=0 -> lfsr_seed=SEED.
